// File: rtl/credit_pool_arbiter.sv
// Shared up/down credit pool with round-robin consume arbitration and one return port.
// Latency: grant is combinational from registered state; pool update visible next cycle.
// Backpressure: a candidate short of credits blocks all grants (no bypass); returns always accepted.
module credit_pool_arbiter #(
  parameter int NumReq      = 4,
  parameter int WIDTH       = 8,
  parameter int InitCredits = 2**WIDTH-1,
  parameter int MaxCredits  = 2**WIDTH-1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic [NumReq-1:0]       req_valid_i,
  input  logic [NumReq*WIDTH-1:0] req_amount_i,
  output logic [NumReq-1:0]       req_ready_o,
  input  logic                    ret_valid_i,
  input  logic [WIDTH-1:0]        ret_amount_i,
  output logic [WIDTH-1:0]        credits_o,
  output logic                    err_o,
  output logic                    busy_o
);

  // Pointer needs at least one bit even for a single requester.
  localparam int PW = (NumReq > 1) ? $clog2(NumReq) : 1;

  localparam logic [WIDTH-1:0] InitVal = WIDTH'(InitCredits);
  localparam logic [WIDTH:0]   MaxExt  = (WIDTH+1)'(MaxCredits);
  localparam logic [PW-1:0]    LastIdx = PW'(NumReq - 1);

  logic [WIDTH-1:0] credits_q;
  logic [PW-1:0]    ptr_q;
  logic             err_q;

  logic             cand_found;
  logic [PW-1:0]    cand_idx;
  logic [WIDTH-1:0] cand_amt;
  logic             grant;
  logic [PW-1:0]    ptr_nxt;
  logic [WIDTH:0]   pool_sum;
  logic             pool_over;
  logic [WIDTH-1:0] credits_nxt;

  // Find the first valid requester at or after the pointer, wrapping around.
  always_comb begin
    int j;
    j          = 0;
    cand_found = 1'b0;
    cand_idx   = '0;
    cand_amt   = '0;
    for (int k = 0; k < NumReq; k++) begin
      j = (int'(ptr_q) + k) % NumReq;
      if (!cand_found && req_valid_i[j]) begin
        cand_found = 1'b1;
        cand_idx   = PW'(j);
        cand_amt   = req_amount_i[j*WIDTH +: WIDTH];
      end
    end
  end

  // Grant only the candidate, and only if the pool covers it; smaller requests
  // behind a blocked candidate wait so large requests cannot be starved.
  // Returns are deliberately excluded so there is no return-to-grant path.
  always_comb begin
    grant = cand_found && (cand_amt <= credits_q) && !clear_i;
    for (int i = 0; i < NumReq; i++) begin
      req_ready_o[i] = grant && (cand_idx == PW'(i));
    end
  end

  // Next pool value in WIDTH+1 bits so the overflow check sees the true sum.
  always_comb begin
    pool_sum = {1'b0, credits_q}
             - (grant       ? {1'b0, cand_amt}     : '0)
             + (ret_valid_i ? {1'b0, ret_amount_i} : '0);
    pool_over   = (pool_sum > MaxExt);
    credits_nxt = pool_over ? MaxExt[WIDTH-1:0] : pool_sum[WIDTH-1:0];
    ptr_nxt     = (cand_idx == LastIdx) ? '0 : cand_idx + 1'b1;
  end

  // State register; clear overrides grants and discards same-cycle returns.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credits_q <= InitVal;
      ptr_q     <= '0;
      err_q     <= 1'b0;
    end else if (clear_i) begin
      credits_q <= InitVal;
      ptr_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_nxt;
      if (grant) begin
        ptr_q <= ptr_nxt;
      end
      if (pool_over) begin
        err_q <= 1'b1;
      end
    end
  end

  assign credits_o = credits_q;
  assign err_o     = err_q;
  assign busy_o    = (credits_q != InitVal);

endmodule

// File: tb/tb_credit_pool_arbiter.sv
module tb_credit_pool_arbiter;

  localparam int NumReq = 4;
  localparam int WIDTH  = 8;

  logic                    clk_i;
  logic                    rst_ni;
  logic                    clear_i;
  logic [NumReq-1:0]       req_valid_i;
  logic [NumReq*WIDTH-1:0] req_amount_i;
  logic [NumReq-1:0]       req_ready_o;
  logic                    ret_valid_i;
  logic [WIDTH-1:0]        ret_amount_i;
  logic [WIDTH-1:0]        credits_o;
  logic                    err_o;
  logic                    busy_o;

  int checks = 0;
  int errors = 0;

  credit_pool_arbiter #(
    .NumReq(NumReq),
    .WIDTH(WIDTH),
    .InitCredits(10),
    .MaxCredits(255)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .clear_i(clear_i),
    .req_valid_i(req_valid_i),
    .req_amount_i(req_amount_i),
    .req_ready_o(req_ready_o),
    .ret_valid_i(ret_valid_i),
    .ret_amount_i(ret_amount_i),
    .credits_o(credits_o),
    .err_o(err_o),
    .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; clear_i = 1'b0; req_valid_i = '0; req_amount_i = '0;
    ret_valid_i = 1'b0; ret_amount_i = '0;
    #12;
    checks++; if (credits_o !== 8'd10) begin errors++; $display("FAIL reset_credits got %0d want 10", credits_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    cyc();
    req_valid_i  = 4'hF;
    req_amount_i = {8'd1, 8'd1, 8'd1, 8'd1};
    for (int i = 0; i < 8; i++) begin
      #1;
      exp = 4'b0001 << (i % 4);
      checks++; if (req_ready_o !== exp) begin errors++; $display("FAIL rr_grant_%0d got %b want %b", i, req_ready_o, exp); end
      cyc();
    end
    req_valid_i = '0;
    checks++; if (credits_o !== 8'd2) begin errors++; $display("FAIL rr_credits got %0d want 2", credits_o); end
  endtask

  task automatic test_no_bypass();
    ret_valid_i = 1'b1; ret_amount_i = 8'd1;
    cyc();
    ret_valid_i = 1'b0;
    checks++; if (credits_o !== 8'd3) begin errors++; $display("FAIL nb_setup got %0d want 3", credits_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL nb_busy got %b want 1", busy_o); end
    req_valid_i  = 4'b0011;
    req_amount_i = {8'd0, 8'd0, 8'd1, 8'd5};
    #1;
    checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL nb_blocked got %b want 0000", req_ready_o); end
    cyc();
    checks++; if (credits_o !== 8'd3) begin errors++; $display("FAIL nb_hold got %0d want 3", credits_o); end
    ret_valid_i = 1'b1; ret_amount_i = 8'd2;
    #1;
    checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL nb_no_ret_path got %b want 0000", req_ready_o); end
    cyc();
    ret_valid_i = 1'b0;
    checks++; if (credits_o !== 8'd5) begin errors++; $display("FAIL nb_after_ret got %0d want 5", credits_o); end
    #1;
    checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL nb_grant0 got %b want 0001", req_ready_o); end
    cyc();
    checks++; if (credits_o !== 8'd0) begin errors++; $display("FAIL nb_drained got %0d want 0", credits_o); end
    req_amount_i = {8'd0, 8'd0, 8'd0, 8'd0};
    #1;
    checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL nb_zero_amt_ptr1 got %b want 0010", req_ready_o); end
    cyc();
    req_valid_i = '0;
    checks++; if (credits_o !== 8'd0) begin errors++; $display("FAIL nb_zero_amt_pool got %0d want 0", credits_o); end
  endtask

  task automatic test_grant_with_return();
    ret_valid_i = 1'b1; ret_amount_i = 8'd4;
    cyc();
    ret_valid_i = 1'b0;
    checks++; if (credits_o !== 8'd4) begin errors++; $display("FAIL gr_setup got %0d want 4", credits_o); end
    req_valid_i  = 4'b0100;
    req_amount_i = {8'd0, 8'd3, 8'd0, 8'd0};
    ret_valid_i  = 1'b1; ret_amount_i = 8'd6;
    #1;
    checks++; if (req_ready_o !== 4'b0100) begin errors++; $display("FAIL gr_grant2 got %b want 0100", req_ready_o); end
    cyc();
    req_valid_i = '0; ret_valid_i = 1'b0;
    checks++; if (credits_o !== 8'd7) begin errors++; $display("FAIL gr_net got %0d want 7", credits_o); end
  endtask

  task automatic test_overflow_clear();
    ret_valid_i = 1'b1; ret_amount_i = 8'd243;
    cyc();
    checks++; if (credits_o !== 8'd250) begin errors++; $display("FAIL ov_setup got %0d want 250", credits_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL ov_err_pre got %b want 0", err_o); end
    ret_amount_i = 8'd10;
    cyc();
    ret_valid_i = 1'b0;
    checks++; if (credits_o !== 8'd255) begin errors++; $display("FAIL ov_sat got %0d want 255", credits_o); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL ov_err got %b want 1", err_o); end
    cyc();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL ov_err_sticky got %b want 1", err_o); end
    clear_i = 1'b1;
    req_valid_i  = 4'hF;
    req_amount_i = {8'd1, 8'd1, 8'd1, 8'd1};
    ret_valid_i  = 1'b1; ret_amount_i = 8'd5;
    #1;
    checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL clr_ready got %b want 0000", req_ready_o); end
    cyc();
    clear_i = 1'b0; ret_valid_i = 1'b0;
    checks++; if (credits_o !== 8'd10) begin errors++; $display("FAIL clr_credits got %0d want 10", credits_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL clr_err got %b want 0", err_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL clr_busy got %b want 0", busy_o); end
    #1;
    checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL clr_ptr got %b want 0001", req_ready_o); end
    req_valid_i  = 4'b0001;
    req_amount_i = {8'd0, 8'd0, 8'd0, 8'd10};
    #1;
    checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL exact_fit got %b want 0001", req_ready_o); end
    cyc();
    req_valid_i = '0;
    checks++; if (credits_o !== 8'd0) begin errors++; $display("FAIL exact_fit_pool got %0d want 0", credits_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL exact_fit_busy got %b want 1", busy_o); end
  endtask

  task automatic test_async_reset();
    ret_valid_i = 1'b1; ret_amount_i = 8'd5;
    cyc();
    ret_amount_i = 8'd255;
    cyc();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL ar_err_pre got %b want 1", err_o); end
    req_valid_i  = 4'hF;
    req_amount_i = {8'd1, 8'd1, 8'd1, 8'd1};
    ret_amount_i = 8'd1;
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (credits_o !== 8'd10) begin errors++; $display("FAIL ar_credits got %0d want 10", credits_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL ar_err got %b want 0", err_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ar_busy got %b want 0", busy_o); end
    checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL ar_ptr got %b want 0001", req_ready_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    ret_valid_i = 1'b0;
    #1;
    checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL ar_restart0 got %b want 0001", req_ready_o); end
    cyc();
    checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL ar_restart1 got %b want 0010", req_ready_o); end
    checks++; if (credits_o !== 8'd9) begin errors++; $display("FAIL ar_credits_after got %0d want 9", credits_o); end
    req_valid_i = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_no_bypass();
    test_grant_with_return();
    test_overflow_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
